// File: rtl/hex_display_pkg.sv
// Shared constants for the hex 7-segment display driver: field width, blank code
// and the active-low nibble-to-segment table (bit0=a .. bit6=g).
package hex_display_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned NUM_HEX = 16;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Entry n is the active-low pattern for hex digit n (entry 0 is the rightmost).
  localparam logic [NUM_HEX-1:0][SEG_W-1:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [SEG_W-1:0] seg_lookup(input logic [NIB_W-1:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/hex_seg_rom.sv
// Combinational nibble-to-segment decoder, one instance per displayed digit.
module hex_seg_rom
  import hex_display_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = seg_lookup(nibble);
  end

endmodule

// File: rtl/hex_display_driver.sv
// Multi-digit 7-segment driver: latched value with enable, leading-zero blanking and
// blink, presented as a parallel segment bus and as a scanned single-digit output.
module hex_display_driver
  import hex_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned BLINK_DIV  = 25000000,
  parameter int unsigned SCAN_DIV   = 50000
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        load,
  input  logic [4*NUM_DIGITS-1:0]     value,
  input  logic [NUM_DIGITS-1:0]       digit_en,
  input  logic [NUM_DIGITS-1:0]       blink_mask,
  input  logic                        blank_lz,
  output logic [7*NUM_DIGITS-1:0]     seg_n,
  output logic [6:0]                  scan_seg_n,
  output logic [NUM_DIGITS-1:0]       scan_sel_n,
  output logic                        blink_phase
);

  localparam int unsigned VAL_W     = NIB_W * NUM_DIGITS;
  localparam int unsigned SEG_BUS_W = SEG_W * NUM_DIGITS;
  localparam int unsigned BLINK_CW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned SCAN_CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [VAL_W-1:0]      val_q;
  logic [NUM_DIGITS-1:0] en_q;
  logic [NUM_DIGITS-1:0] blink_q;
  logic                  lz_q;

  logic [BLINK_CW-1:0]   blink_cnt;
  logic [SCAN_CW-1:0]    scan_cnt;
  logic [IDX_W-1:0]      scan_idx;

  logic [SEG_W-1:0]      rom_seg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] upper_nz;
  logic [NUM_DIGITS-1:0] blank_c;
  logic [SEG_BUS_W-1:0]  next_seg_c;
  logic [SEG_W-1:0]      scan_field_c;
  logic [NUM_DIGITS-1:0] scan_sel_c;

  // Display settings are captured together on a load strobe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      val_q   <= '0;
      en_q    <= '0;
      blink_q <= '0;
      lz_q    <= 1'b0;
    end else if (load) begin
      val_q   <= value;
      en_q    <= digit_en;
      blink_q <= blink_mask;
      lz_q    <= blank_lz;
    end
  end

  // Free-running blink timebase; phase flips each time the counter wraps.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_CW'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + BLINK_CW'(1);
    end
  end

  // Scan timebase: each digit is held for SCAN_DIV cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_CW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      if (scan_idx == IDX_W'(NUM_DIGITS - 1)) begin
        scan_idx <= '0;
      end else begin
        scan_idx <= scan_idx + IDX_W'(1);
      end
    end else begin
      scan_cnt <= scan_cnt + SCAN_CW'(1);
    end
  end

  // upper_nz[i]: some nibble at position i or above is non-zero.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    hex_seg_rom u_rom (
      .nibble (val_q[NIB_W*g +: NIB_W]),
      .seg_c  (rom_seg[g])
    );
    assign upper_nz[g] = |val_q[VAL_W-1:NIB_W*g];
  end

  always_comb begin
    blank_c = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      blank_c[i] = !en_q[i]
                 || (blink_q[i] && blink_phase)
                 || (lz_q && (i != 0) && !upper_nz[i]);
    end
  end

  always_comb begin
    next_seg_c = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      next_seg_c[SEG_W*i +: SEG_W] = blank_c[i] ? SEG_BLANK : rom_seg[i];
    end
  end

  // Select and data come from the same index so they switch on the same edge.
  always_comb begin
    scan_field_c = SEG_BLANK;
    scan_sel_c   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx == IDX_W'(i)) begin
        scan_field_c  = next_seg_c[SEG_W*i +: SEG_W];
        scan_sel_c[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seg_n      <= '1;
      scan_seg_n <= SEG_BLANK;
      scan_sel_n <= '1;
    end else begin
      seg_n      <= next_seg_c;
      scan_seg_n <= scan_field_c;
      scan_sel_n <= scan_sel_c;
    end
  end

endmodule

// File: tb/tb_hex_display_driver.sv
// Directed self-checking bench for hex_display_driver (4 digits, fast blink and scan).
module tb_hex_display_driver;

  localparam int unsigned ND = 4;

  logic          clk;
  logic          resetn;
  logic          load;
  logic [15:0]   value;
  logic [3:0]    digit_en;
  logic [3:0]    blink_mask;
  logic          blank_lz;
  logic [27:0]   seg_n;
  logic [6:0]    scan_seg_n;
  logic [3:0]    scan_sel_n;
  logic          blink_phase;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [6:0] tab [16];

  hex_display_driver #(
    .NUM_DIGITS (ND),
    .BLINK_DIV  (4),
    .SCAN_DIV   (2)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .load        (load),
    .value       (value),
    .digit_en    (digit_en),
    .blink_mask  (blink_mask),
    .blank_lz    (blank_lz),
    .seg_n       (seg_n),
    .scan_seg_n  (scan_seg_n),
    .scan_sel_n  (scan_sel_n),
    .blink_phase (blink_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release, used as the timing reference for blink and scan.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] pack4(input logic [6:0] d3, input logic [6:0] d2,
                                        input logic [6:0] d1, input logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  function automatic logic [3:0] exp_sel(input int c);
    logic [3:0] s;
    s = 4'hF;
    s[((c - 1) / 2) % 4] = 1'b0;
    return s;
  endfunction

  // Returns at a negedge with the load's effect visible on seg_n.
  task automatic do_load(input logic [15:0] v, input logic [3:0] en,
                         input logic [3:0] bm, input logic lz);
    @(negedge clk);
    value = v; digit_en = en; blink_mask = bm; blank_lz = lz; load = 1'b1;
    @(negedge clk);
    load = 1'b0; value = 16'hFFFF; digit_en = 4'h0; blink_mask = 4'hF; blank_lz = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg"},   32'(seg_n),       32'h0FFF_FFFF);
    check({tag, "_sseg"},  32'(scan_seg_n),  32'h7F);
    check({tag, "_ssel"},  32'(scan_sel_n),  32'hF);
    check({tag, "_phase"}, 32'(blink_phase), 32'h0);
  endtask

  initial begin
    logic [6:0]  f [4];
    logic [27:0] exp_seg;
    logic [3:0]  s;
    int          idx;

    tab[0]  = 7'h40; tab[1]  = 7'h79; tab[2]  = 7'h24; tab[3]  = 7'h30;
    tab[4]  = 7'h19; tab[5]  = 7'h12; tab[6]  = 7'h02; tab[7]  = 7'h78;
    tab[8]  = 7'h00; tab[9]  = 7'h10; tab[10] = 7'h08; tab[11] = 7'h03;
    tab[12] = 7'h46; tab[13] = 7'h21; tab[14] = 7'h06; tab[15] = 7'h0E;

    resetn = 1'b0; load = 1'b0; value = '0; digit_en = '0; blink_mask = '0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    resetn = 1'b1;
    #2;
    check_reset_outputs("rst_rel");

    // Nibble sweep against the segment table, and the 1234 example.
    for (int n = 0; n < 16; n++) begin
      do_load({4{4'(n)}}, 4'hF, 4'h0, 1'b0);
      check($sformatf("sweep_%0d", n), 32'(seg_n), 32'(pack4(tab[n], tab[n], tab[n], tab[n])));
    end
    do_load(16'h1234, 4'hF, 4'h0, 1'b0);
    check("val_1234", 32'(seg_n), 32'(pack4(7'h79, 7'h24, 7'h30, 7'h19)));

    // Leading-zero blanking, including the all-zero value.
    do_load(16'h0050, 4'hF, 4'h0, 1'b1);
    check("lz_0050", 32'(seg_n), 32'(pack4(7'h7F, 7'h7F, 7'h12, 7'h40)));
    do_load(16'h0000, 4'hF, 4'h0, 1'b1);
    check("lz_0000", 32'(seg_n), 32'(pack4(7'h7F, 7'h7F, 7'h7F, 7'h40)));
    do_load(16'h0050, 4'hD, 4'h0, 1'b1);
    check("lz_dis1", 32'(seg_n), 32'(pack4(7'h7F, 7'h7F, 7'h7F, 7'h40)));
    do_load(16'h0050, 4'hF, 4'h0, 1'b0);
    check("lz_off", 32'(seg_n), 32'(pack4(7'h40, 7'h40, 7'h12, 7'h40)));

    // Back-to-back loads: the second one wins one cycle later.
    @(negedge clk);
    value = 16'h1111; digit_en = 4'hF; blink_mask = 4'h0; blank_lz = 1'b0; load = 1'b1;
    @(negedge clk);
    value = 16'h2222;
    @(negedge clk);
    load = 1'b0;
    check("b2b_first", 32'(seg_n), 32'(pack4(7'h79, 7'h79, 7'h79, 7'h79)));
    @(negedge clk);
    check("b2b_second", 32'(seg_n), 32'(pack4(7'h24, 7'h24, 7'h24, 7'h24)));

    // Scan of a static value.
    do_load(16'h1234, 4'hF, 4'h0, 1'b0);
    f[3] = 7'h79; f[2] = 7'h24; f[1] = 7'h30; f[0] = 7'h19;
    for (int k = 0; k < 12; k++) begin
      idx = ((cyc - 1) / 2) % 4;
      check($sformatf("scan_sel_%0d", k), 32'(scan_sel_n), 32'(exp_sel(cyc)));
      check($sformatf("scan_seg_%0d", k), 32'(scan_seg_n), 32'(f[idx]));
      @(negedge clk);
    end

    // Disabled digits 0 and 2.
    do_load(16'h1234, 4'b1010, 4'h0, 1'b0);
    check("en_1010", 32'(seg_n), 32'(pack4(7'h79, 7'h7F, 7'h30, 7'h7F)));
    f[3] = 7'h79; f[2] = 7'h7F; f[1] = 7'h30; f[0] = 7'h7F;
    for (int k = 0; k < 8; k++) begin
      idx = ((cyc - 1) / 2) % 4;
      check($sformatf("en_scan_%0d", k), 32'(scan_seg_n), 32'(f[idx]));
      @(negedge clk);
    end

    // Blink on digit 0; seg_n follows the phase held before the last edge.
    do_load(16'hABCD, 4'hF, 4'b0001, 1'b0);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("phase_%0d", k), 32'(blink_phase), 32'((cyc / 4) % 2));
      exp_seg = pack4(7'h08, 7'h03, 7'h46, (((cyc - 1) / 4) % 2 == 1) ? 7'h7F : 7'h21);
      check($sformatf("blink_seg_%0d", k), 32'(seg_n), 32'(exp_seg));
      @(negedge clk);
    end

    // Asynchronous reset mid-scan and mid-blink.
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check_reset_outputs("async");
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check_reset_outputs("async_rel");
    @(negedge clk);
    s = 4'b1110;
    check("restart_sel1", 32'(scan_sel_n), 32'(s));
    check("restart_phase", 32'(blink_phase), 32'h0);
    check("restart_seg", 32'(seg_n), 32'h0FFF_FFFF);
    @(negedge clk);
    check("restart_sel2", 32'(scan_sel_n), 32'(s));
    @(negedge clk);
    check("restart_sel3", 32'(scan_sel_n), 32'h0000_000D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
